// File: rtl/tx_triple_sched_pkg.sv
// Shared types and constants for the triple-redundant TX scheduler (and later the RX voter).
package tx_triple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] ID_FIRST = 2'd1;
  localparam logic [1:0] ID_LAST  = 2'd3;

  localparam int ID_LSB  = 0;
  localparam int ID_MSB  = 3;
  localparam int SEQ_LSB = 4;
  localparam int SEQ_MSB = 7;

  function automatic logic [7:0] id_byte(input logic [3:0] seq, input logic [1:0] id);
    logic [7:0] b;
    b                  = '0;
    b[SEQ_MSB:SEQ_LSB] = seq;
    b[ID_MSB:ID_LSB]   = {2'b00, id};
    return b;
  endfunction

endpackage

// File: rtl/tx_triple_sched_if.sv
// Control, frame-buffer read port and MAC byte interface of the TX scheduler.
interface tx_triple_sched_if #(parameter int ADDR_W = 12);
  logic              start;
  logic [ADDR_W-1:0] frame_len;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              tx_en;
  logic [7:0]        txdata;
  logic [1:0]        cur_id;

  modport master (
    input  start, frame_len, buf_data,
    output busy, done, err, buf_addr, tx_en, txdata, cur_id
  );

  modport slave (
    output start, frame_len, buf_data,
    input  busy, done, err, buf_addr, tx_en, txdata, cur_id
  );
endinterface

// File: rtl/tx_triple_sched_gap_timer.sv
// Loadable down-counter that flags the last cycle of a GAP_CYCLES-long idle window.
module tx_gap_timer #(
  parameter int GAP_CYCLES = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= CNT_W'(GAP_CYCLES - 1);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) r_active <= 1'b0;
      else             r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = r_active && (r_cnt == '0);

endmodule

// File: rtl/tx_triple_sched.sv
// Sends one buffered frame COPIES times with the copy ID patched in at WHEREISID.
// Optional build macro TX_SEQ_TAG_EN puts a 4-bit frame sequence tag in the ID byte's upper nibble.
module tx_triple_sched
  import tx_triple_pkg::*;
#(
  parameter int WHEREISID  = 22,
  parameter int COPIES     = 3,
  parameter int GAP_CYCLES = 12,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  tx_triple_sched_if.master tx
);

  localparam logic [1:0] LAST_ID = (COPIES >= int'(ID_LAST)) ? ID_LAST : 2'(COPIES);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_len, r_buf_addr;
  logic [1:0]        r_cur_id;
  logic              r_busy, r_done, r_err;
  logic              r_vld_p1, r_isid_p1;
  logic              r_tx_en;
  logic [7:0]        r_txdata;
  logic              w_accept, w_reject, w_gap_load, w_next_copy, w_last_addr, w_expired;
  logic [3:0]        w_seq;

`ifdef TX_SEQ_TAG_EN
  logic [3:0] r_seq;
  always_ff @(posedge clk) begin
    if (rst)                          r_seq <= '0;
    else if (w_state_nxt == ST_DONE)  r_seq <= r_seq + 4'd1;
  end
  assign w_seq = r_seq;
`else
  assign w_seq = 4'd0;
`endif

  assign w_last_addr = (r_buf_addr == r_len - ADDR_W'(1));

  tx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_gap_load),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_gap_load  = 1'b0;
    w_next_copy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx.start) begin
          if (tx.frame_len > ADDR_W'(WHEREISID)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_PREFETCH;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      ST_PREFETCH: w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_last_addr) begin
          w_gap_load  = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_expired) begin
          if (r_cur_id < LAST_ID) begin
            w_next_copy = 1'b1;
            w_state_nxt = ST_PREFETCH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_buf_addr <= '0;
      r_cur_id   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_isid_p1  <= 1'b0;
      r_tx_en    <= 1'b0;
      r_txdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_len    <= tx.frame_len;
        r_cur_id <= ID_FIRST;
        r_busy   <= 1'b1;
      end else if (w_next_copy) begin
        r_cur_id <= r_cur_id + 2'd1;
      end else if (w_state_nxt == ST_DONE) begin
        r_busy   <= 1'b0;
        r_cur_id <= '0;
      end
      // Address stage: parks at 0 outside SEND so it never runs past len-1
      r_buf_addr <= (r_state == ST_SEND && !w_last_addr) ? r_buf_addr + ADDR_W'(1) : '0;
      // p1 stage: BRAM output now holds the byte addressed last cycle
      r_vld_p1  <= (r_state == ST_SEND);
      r_isid_p1 <= (r_state == ST_SEND) && (r_buf_addr == ADDR_W'(WHEREISID));
      // Output stage
      r_tx_en  <= r_vld_p1;
      r_txdata <= !r_vld_p1 ? 8'h00 : (r_isid_p1 ? id_byte(w_seq, r_cur_id) : tx.buf_data);
    end
  end

  assign tx.busy     = r_busy;
  assign tx.done     = r_done;
  assign tx.err      = r_err;
  assign tx.buf_addr = r_buf_addr;
  assign tx.tx_en    = r_tx_en;
  assign tx.txdata   = r_txdata;
  assign tx.cur_id   = r_cur_id;

endmodule

// File: tb/tb_tx_triple_sched.sv
// Directed/randomized bench for tx_triple_sched against a cycle-timeline reference model.
module tb_tx_triple_sched;

  localparam int WHEREISID = 22;
  localparam int COPIES    = 3;
  localparam int GAP       = 12;
  localparam int ADDR_W    = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_triple_sched_if #(.ADDR_W(ADDR_W)) bus();

  tx_triple_sched #(
    .WHEREISID (WHEREISID),
    .COPIES    (COPIES),
    .GAP_CYCLES(GAP),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  logic [7:0] mem [0:4095];
  always @(posedge clk) bus.buf_data <= mem[bus.buf_addr];

  int n_cmp    = 0;
  int n_fail   = 0;
  int m_frames = 0;

  // Expected {busy, done, err, tx_en, txdata, cur_id} c cycles after the accepting edge.
  function automatic logic [13:0] model(input int c, input int len);
    int         p;
    int         t;
    int         base;
    int         idx;
    logic       ten;
    logic [7:0] td;
    logic [1:0] id;
    logic [3:0] seq;
    p   = len + 1 + GAP;
    t   = COPIES * p;
    ten = 1'b0;
    td  = 8'h00;
`ifdef TX_SEQ_TAG_EN
    seq = 4'(m_frames % 16);
`else
    seq = 4'h0;
`endif
    for (int k = 0; k < COPIES; k++) begin
      base = k * p;
      if (c >= base + 3 && c <= base + 2 + len) begin
        idx = c - base - 3;
        ten = 1'b1;
        td  = (idx == WHEREISID) ? {seq, 2'b00, 2'(k + 1)} : mem[idx];
      end
    end
    id = (c < t) ? 2'(c / p + 1) : 2'd0;
    return {(c < t), (c == t), 1'b0, ten, td, id};
  endfunction

  task automatic check(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {bus.busy, bus.done, bus.err, bus.tx_en, bus.txdata, bus.cur_id};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int len, input bit pulses, input int abort_at, input string name);
    int p;
    int t;
    p = len + 1 + GAP;
    t = COPIES * p;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.frame_len = ADDR_W'(len);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c <= t + 2; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), model(c, len));
      if (c == abort_at) begin
        rst = 1'b1;
        return;
      end
      bus.start = 1'b0;
      if (pulses && c < t && $urandom_range(7) == 0) begin
        bus.start     = 1'b1;
        bus.frame_len = ADDR_W'($urandom_range(4095));
      end
    end
    bus.start = 1'b0;
    m_frames++;
  endtask

  task automatic reject(input int len, input string name);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.frame_len = ADDR_W'(len);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check({name, " err"}, 14'h0800);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d", name, i), 14'h0000);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.frame_len = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset held", 14'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("reset released", 14'h0000);

    run_frame(64, 1'b0, -1, "t1 len64");

    reject(22, "t2 len22");
    reject(0, "t2 len0");

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    run_frame(40, 1'b1, -1, "t3 restart");

    run_frame(50, 1'b0, (50 + 1 + GAP) + 3 + 30, "t4 abort");
    @(negedge clk);
    check("t4 in reset", 14'h0000);
    rst      = 1'b0;
    m_frames = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4 post-reset%0d", i), 14'h0000);
    end
    run_frame(50, 1'b0, -1, "t4 resend");

    run_frame(23, 1'b0, -1, "t5 len23");

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    m_frames = 0;
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_frame(23 + int'($urandom_range(17)), 1'b1, -1, $sformatf("t6 f%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
